// File: rtl/chunked_seq_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// The chunk count and index width are derived here so the top and the bench agree on them.
package chunked_seq_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int calc_n(input int width, input int chunk);
      return width / chunk;
   endfunction

   function automatic int calc_idx_w(input int width, input int chunk);
      int n;
      n = width / chunk;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit chunk_ok(input int width, input int chunk);
      return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/chunked_seq_adder_chunk_add.sv
// CHUNK-bit combinational ripple adder built from full-adder cells.
// A single instance is reused every cycle by the sequential top.
module chunk_add #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_ci,
   output logic [CHUNK-1:0] o_s,
   output logic             o_co
);

   logic [CHUNK:0] w_c;

   assign w_c[0] = i_ci;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign o_s[i]     = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i+1]   = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_co = w_c[CHUNK];

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per clock,
// carry held in a register between chunks, valid/ready on both sides.
module chunked_seq_adder
   import chunked_seq_adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N     = calc_n(WIDTH, CHUNK);
   localparam int IDX_W = calc_idx_w(WIDTH, CHUNK);
   localparam logic [IDX_W-1:0] LAST_K = IDX_W'(N - 1);

   if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
      $error("chunked_seq_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   state_t                   r_state;
   logic [N-1:0][CHUNK-1:0]  r_a;
   logic [N-1:0][CHUNK-1:0]  r_b;
   logic [N-1:0][CHUNK-1:0]  r_sum;
   logic                     r_carry;
   logic [IDX_W-1:0]         r_k;
   logic                     r_cout;
   logic                     r_ovf;
   logic                     r_out_valid;

   logic [CHUNK-1:0]         w_s;
   logic                     w_co;
   logic                     w_last;
   logic                     w_msb_cin;

   chunk_add #(.CHUNK(CHUNK)) u_chunk_add (
      .i_a  (r_a[r_k]),
      .i_b  (r_b[r_k]),
      .i_ci (r_carry),
      .o_s  (w_s),
      .o_co (w_co)
   );

   assign w_last    = (r_k == LAST_K);
   // Carry into the MSB recovered from the MSB sum bit; only meaningful on the last chunk.
   assign w_msb_cin = r_a[N-1][CHUNK-1] ^ r_b[N-1][CHUNK-1] ^ w_s[CHUNK-1];

   assign in_ready  = !rst && (r_state == ST_IDLE);
   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_k         <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  r_carry <= cin ^ sub;
                  r_k     <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_sum[r_k] <= w_s;
               r_carry    <= w_co;
               r_k        <= r_k + 1'b1;
               if (w_last) begin
                  r_cout      <= w_co;
                  r_ovf       <= w_msb_cin ^ w_co;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
